// File: rtl/ssb_pkg.sv
// Shared constants and types for the small system bus (SSB) arbiter.
//   SSB_ADDR_W / SSB_DATA_W : bus address and data widths
//   SsbHost* / SsbDev*      : host and device index assignments
//   ssb_rsp_t               : response pipeline register payload
package ssb_pkg;

    localparam int unsigned SSB_ADDR_W  = 32;
    localparam int unsigned SSB_DATA_W  = 32;
    localparam int unsigned SSB_BE_W    = 4;
    localparam int unsigned SSB_BURST_W = 3;

    // Host indices
    localparam int unsigned SsbHostDbg   = 0;
    localparam int unsigned SsbHostInstr = 1;
    localparam int unsigned SsbHostData  = 2;

    // Device indices
    localparam int unsigned SsbDevSram   = 0;
    localparam int unsigned SsbDevDbgMem = 1;

    // Id fields are sized generously so the struct does not depend on module parameters
    localparam int unsigned SsbHostIdW = 4;
    localparam int unsigned SsbDevIdW  = 4;

    typedef struct packed {
        logic                  valid;
        logic [SsbHostIdW-1:0] host;
        logic [SsbDevIdW-1:0]  dev;
        logic                  err;
    } ssb_rsp_t;

endpackage

// File: rtl/ssb_rr_arb.sv
// Round-robin picker: grants the first eligible requester after last_i.
//   req_i  : request vector
//   mask_i : requesters excluded from this arbitration
//   last_i : index of the most recently granted requester
//   gnt_o  : one-hot grant (all zero when nothing is eligible)
//   idx_o  : index of the granted requester (0 when no grant)
module ssb_rr_arb #(
    parameter int unsigned N    = 3,
    // Derived from N; not intended to be overridden
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    input  logic [IdxW-1:0] last_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic [N-1:0] elig;
    logic         found;
    int unsigned  cand;

    // Scan N positions starting one past the last winner; the last winner is checked last
    always_comb begin
        elig  = req_i & ~mask_i;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(last_i) + i) % N;
            if (!found && elig[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/ssb_arbiter.sv
// Multi-host to multi-device bus arbiter with address decode and a one-stage
// response pipeline. Grant and device request are combinational in the request
// cycle; the response (rvalid/err/rdata) follows exactly one cycle later.
//   clk_sys_i, rst_sys_i           : clock, async active-high reset
//   host_req/addr/wdata/we/be_i     : per-host request channel
//   host_gnt_o                      : one-hot grant (same cycle)
//   host_rvalid_o, host_err_o       : one-hot response valid and error
//   host_rdata_o                    : shared read data, 0 without rvalid
//   dev_req_o, dev_addr/wdata/we/be : selected device access
//   dev_rdata_i                     : per-device read data, one cycle after dev_req_o
module ssb_arbiter
    import ssb_pkg::*;
#(
    parameter int unsigned            NumHosts   = 3,
    parameter int unsigned            NumDevices = 2,
    parameter logic [SSB_ADDR_W-1:0]  DevBase [NumDevices] = '{32'h00000000, 32'h1a110000},
    parameter logic [SSB_ADDR_W-1:0]  DevMask [NumDevices] = '{32'h0000FFFF, 32'h0000FFFF},
    parameter int unsigned            MaxBurst   = 4
) (
    input  logic                                 clk_sys_i,
    input  logic                                 rst_sys_i,
    input  logic [NumHosts-1:0]                  host_req_i,
    input  logic [NumHosts-1:0][SSB_ADDR_W-1:0]  host_addr_i,
    input  logic [NumHosts-1:0][SSB_DATA_W-1:0]  host_wdata_i,
    input  logic [NumHosts-1:0]                  host_we_i,
    input  logic [NumHosts-1:0][SSB_BE_W-1:0]    host_be_i,
    output logic [NumHosts-1:0]                  host_gnt_o,
    output logic [NumHosts-1:0]                  host_rvalid_o,
    output logic [NumHosts-1:0]                  host_err_o,
    output logic [SSB_DATA_W-1:0]                host_rdata_o,
    output logic [NumDevices-1:0]                dev_req_o,
    output logic [SSB_ADDR_W-1:0]                dev_addr_o,
    output logic [SSB_DATA_W-1:0]                dev_wdata_o,
    output logic                                 dev_we_o,
    output logic [SSB_BE_W-1:0]                  dev_be_o,
    input  logic [NumDevices-1:0][SSB_DATA_W-1:0] dev_rdata_i
);

    localparam int unsigned HostIdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;

    logic [HostIdxW-1:0]    ptr_q, ptr_d;
    logic [SSB_BURST_W-1:0] burst_q, burst_d;
    ssb_rsp_t               rsp_q, rsp_d;

    logic [NumHosts-1:0]    ptr_onehot;
    logic                   other_req;
    logic [NumHosts-1:0]    burst_mask;
    logic [NumHosts-1:0]    req_live;
    logic [NumHosts-1:0]    rr_gnt;
    logic [HostIdxW-1:0]    rr_idx;
    logic [NumHosts-1:0]    gnt;
    logic [HostIdxW-1:0]    gnt_idx;
    logic                   any_gnt;
    logic                   dev_hit;
    logic [SsbDevIdW-1:0]   dev_idx;

    // Burst limiting: the host on a full run sits out one arbitration if anyone else wants the bus
    always_comb begin
        ptr_onehot = NumHosts'(1) << ptr_q;
        other_req  = |(host_req_i & ~ptr_onehot);
        burst_mask = '0;
        if ((burst_q == SSB_BURST_W'(MaxBurst)) && other_req) begin
            burst_mask = ptr_onehot;
        end
        req_live = rst_sys_i ? '0 : host_req_i;
    end

    ssb_rr_arb #(
        .N (NumHosts)
    ) u_rr_arb (
        .req_i  (req_live),
        .mask_i (burst_mask),
        .last_i (ptr_q),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx)
    );

    // Debug host overrides round-robin unless it is the one being burst-masked
    always_comb begin
        gnt     = rr_gnt;
        gnt_idx = rr_idx;
        if (req_live[SsbHostDbg] && !burst_mask[SsbHostDbg]) begin
            gnt     = NumHosts'(1) << SsbHostDbg;
            gnt_idx = HostIdxW'(SsbHostDbg);
        end
    end

    assign any_gnt    = |gnt;
    assign host_gnt_o = gnt;

    // Forward the granted host's request fields; all zero without a grant
    always_comb begin
        dev_addr_o  = '0;
        dev_wdata_o = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        for (int unsigned h = 0; h < NumHosts; h++) begin
            if (gnt[h]) begin
                dev_addr_o  = host_addr_i[h];
                dev_wdata_o = host_wdata_i[h];
                dev_we_o    = host_we_i[h];
                dev_be_o    = host_be_i[h];
            end
        end
    end

    // Address decode; scanning downward lets the lowest matching index win
    always_comb begin
        dev_hit   = 1'b0;
        dev_idx   = '0;
        dev_req_o = '0;
        for (int d = int'(NumDevices) - 1; d >= 0; d--) begin
            if (any_gnt && ((dev_addr_o & ~DevMask[d]) == DevBase[d])) begin
                dev_hit      = 1'b1;
                dev_idx      = SsbDevIdW'(d);
                dev_req_o    = '0;
                dev_req_o[d] = 1'b1;
            end
        end
    end

    // Next state: response capture, last-winner pointer, consecutive-grant count
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = any_gnt;
        rsp_d.host  = SsbHostIdW'(gnt_idx);
        rsp_d.dev   = dev_idx;
        rsp_d.err   = any_gnt && !dev_hit;
        ptr_d       = ptr_q;
        burst_d     = '0;
        if (any_gnt) begin
            ptr_d = gnt_idx;
            if ((gnt_idx == ptr_q) && (burst_q != '0)) begin
                burst_d = (burst_q >= SSB_BURST_W'(MaxBurst)) ? SSB_BURST_W'(MaxBurst)
                                                               : burst_q + SSB_BURST_W'(1);
            end else begin
                burst_d = SSB_BURST_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            ptr_q   <= HostIdxW'(NumHosts - 1);
            burst_q <= '0;
            rsp_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            rsp_q   <= rsp_d;
        end
    end

    // Response fan-out; read data returns 0 on error and when idle
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int unsigned h = 0; h < NumHosts; h++) begin
            if (rsp_q.valid && (rsp_q.host == SsbHostIdW'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_err_o[h]    = rsp_q.err;
            end
        end
        if (rsp_q.valid && !rsp_q.err) begin
            for (int unsigned d = 0; d < NumDevices; d++) begin
                if (rsp_q.dev == SsbDevIdW'(d)) begin
                    host_rdata_o = dev_rdata_i[d];
                end
            end
        end
    end

endmodule
